spi_txn_sequencer: RTL

//   Sequences the shared spi_master between two button requesters. Each requester
//   is a debounced one-shot pulse: REQ0 from BTN0, REQ1 from BTN1.
//   Per request: latch it, arbitrate round-robin, issue one 8-bit transfer with a

---
 rtl/spi_txn_sequencer_if.sv | 28 ++
 rtl/spi_txn_sequencer.sv | 118 +++++++++++
 2 files changed

// File: rtl/spi_txn_sequencer_if.sv
`default_nettype none
// ============================================================================
// spi_txn_sequencer_if : requester pulses, spi_master handshake and status view
// Revision 1.0 - initial release
// ============================================================================
interface spi_txn_sequencer_if;
  logic       req0;
  logic       req1;
  logic       spi_busy;
  logic       spi_done;
  logic [7:0] spi_rx;
  logic       spi_start;
  logic [7:0] spi_tx;
  logic [7:0] led;
  logic       err;
  logic       busy;

  modport master (
    input  req0, req1, spi_busy, spi_done, spi_rx,
    output spi_start, spi_tx, led, err, busy
  );

  modport slave (
    output req0, req1, spi_busy, spi_done, spi_rx,
    input  spi_start, spi_tx, led, err, busy
  );
endinterface
`default_nettype wire

// File: rtl/spi_txn_sequencer.sv
`default_nettype none
// ============================================================================
// spi_txn_sequencer : round-robin sequencing of two requesters onto spi_master
// Revision 1.0 - initial release
// ============================================================================
module spi_txn_sequencer #(
  parameter logic [7:0]  CMD0           = 8'hA5,
  parameter logic [7:0]  CMD1           = 8'h3C,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned GAP_CYCLES     = 16
) (
  input wire logic            clk,
  input wire logic            rst,
  spi_txn_sequencer_if.master bus
);

  localparam int unsigned c_CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int unsigned c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

  localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'(GAP_CYCLES - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_START = 2'd1;
  localparam logic [1:0] c_WAIT  = 2'd2;
  localparam logic [1:0] c_GAP   = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         r_pend;
  logic               r_last;
  logic               r_grant;
  logic [c_CNT_W-1:0] r_cnt;
  logic [7:0]         r_tx;
  logic [7:0]         r_led;
  logic               r_err;

  logic               w_grant;
  logic [1:0]         w_pend_set;
  logic [1:0]         w_pend_clr;

  // Contention goes to whoever did not win last; otherwise the sole pending one.
  always_comb begin
    w_grant = r_pend[1];
    if (r_pend == 2'b11) begin
      w_grant = ~r_last;
    end
  end

  assign w_pend_set = {bus.req1, bus.req0};
  assign w_pend_clr = (r_state == c_START) ? (r_grant ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_pend  <= 2'b00;
      r_last  <= 1'b1;
      r_grant <= 1'b0;
      r_cnt   <= '0;
      r_tx    <= 8'h00;
      r_led   <= 8'h00;
      r_err   <= 1'b0;
    end else begin
      // A new pulse re-arms the latch even in the cycle its grant is consumed.
      r_pend <= (r_pend & ~w_pend_clr) | w_pend_set;

      case (r_state)
        c_IDLE: begin
          if ((r_pend != 2'b00) && !bus.spi_busy) begin
            r_grant <= w_grant;
            r_last  <= w_grant;
            r_tx    <= w_grant ? CMD1 : CMD0;
            r_state <= c_START;
          end
        end

        c_START: begin
          r_cnt   <= '0;
          r_state <= c_WAIT;
        end

        c_WAIT: begin
          if (bus.spi_done) begin
            r_led   <= bus.spi_rx;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_state <= c_GAP;
          end else if (r_cnt == c_TO_LAST) begin
            r_err   <= 1'b1;
            r_cnt   <= '0;
            r_state <= c_GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        c_GAP: begin
          if (r_cnt == c_GAP_LAST) begin
            r_state <= c_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign bus.spi_start = (r_state == c_START);
  assign bus.spi_tx    = r_tx;
  assign bus.led       = r_led;
  assign bus.err       = r_err;
  assign bus.busy      = (r_state != c_IDLE);

endmodule
`default_nettype wire
